// File: rtl/ring_play_ctrl_if.sv
// ring_play_ctrl_if: bundles the requester and consumer side signals of
// ring_play_ctrl.
//   i_req      requester request bits (bit n = requester n)
//   i_data0/1  burst words from requester 0 / 1
//   o_gnt      registered one-hot grant, high for the whole load phase
//   o_busy     high whenever the controller is not idle
//   o_data     ring tail during playback, otherwise 0
//   o_valid    playback qualifier
//   o_first    marks the first word of each rotation
// master = producer/consumer side, slave = controller side.
interface ring_play_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic [1:0]    i_req;
  logic [DW-1:0] i_data0;
  logic [DW-1:0] i_data1;
  logic [1:0]    o_gnt;
  logic          o_busy;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_first;

  modport master (
    output i_req, i_data0, i_data1,
    input  o_gnt, o_busy, o_data, o_valid, o_first
  );

  modport slave (
    input  i_req, i_data0, i_data1,
    output o_gnt, o_busy, o_data, o_valid, o_first
  );
endinterface

// File: rtl/ring_play_ctrl.sv
// ring_play_ctrl: shares a DEPTH-entry recirculating byte ring between two
// requesters. A round-robin winner's burst is shifted into the ring, one gap
// cycle follows, then the ring is replayed RECIRC full rotations.
// Ports:
//   clk  rising-edge clock
//   RST  synchronous active-high reset
//   bus  ring_play_ctrl_if.slave (requests/data in, grant/status/playback out)
module ring_play_ctrl #(
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RECIRC = 2
) (
  input  logic             clk,
  input  logic             RST,
  ring_play_ctrl_if.slave  bus
);
  localparam int unsigned PLAY_LEN = DEPTH * RECIRC;
  localparam int unsigned CW       = $clog2(PLAY_LEN);
  localparam int unsigned PW       = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, GAP, PLAY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;   // 1: last grant went to requester 1
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic [DW-1:0] ring_q [DEPTH];

  logic          shift, load, clr;
  logic [1:0]    pick;
  logic [DW-1:0] wr_word;

  assign wr_word = gnt_q[1] ? bus.i_data1 : bus.i_data0;

  always_comb begin
    if (bus.i_req == 2'b11) pick = last_q ? 2'b01 : 2'b10;
    else                    pick = bus.i_req;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    shift   = 1'b0;
    load    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req != 2'b00) begin
          state_d = LOAD;
          cnt_d   = '0;
          gnt_d   = pick;
          last_d  = pick[1];
        end
      end
      LOAD: begin
        if ((bus.i_req & gnt_q) == 2'b00) begin
          // Granted requester withdrew: discard the partial burst.
          clr     = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          shift = 1'b1;
          load  = 1'b1;
          if (cnt_q == CW'(DEPTH - 1)) begin
            gnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GAP: begin
        state_d = PLAY;
        cnt_d   = '0;
        ph_d    = '0;
      end
      PLAY: begin
        shift = 1'b1;
        if (cnt_q == CW'(PLAY_LEN - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          ph_d  = (ph_q == PW'(DEPTH - 1)) ? '0 : ph_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next-state view so they line up
  // with the state they describe.
  always_comb begin
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == PLAY);
    first_d = (state_d == PLAY) && (ph_d == '0);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      gnt_q   <= '0;
      last_q  <= 1'b1;   // requester 0 wins the first tie
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    if (RST || clr) begin
      for (int unsigned k = 0; k < DEPTH; k++) ring_q[k] <= '0;
    end else if (shift) begin
      for (int unsigned k = 1; k < DEPTH; k++) ring_q[k] <= ring_q[k-1];
      ring_q[0] <= load ? wr_word : ring_q[DEPTH-1];
    end
  end

  assign bus.o_gnt   = gnt_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_valid = valid_q;
  assign bus.o_first = first_q;
  assign bus.o_data  = (state_q == PLAY) ? ring_q[DEPTH-1] : '0;
endmodule
